// File: rtl/ram_rd_ctrl_wave.sv
// Spectrum RAM read controller: scans for the fundamental bin, then reads its
// 2nd..5th harmonics and presents the results with a one-cycle done pulse.
module ram_rd_ctrl_wave #(
    parameter int unsigned DEPTH   = 254,
    parameter int unsigned DC_SKIP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_done,
    input  logic [15:0] rd_data,
    output logic [7:0]  rd_addr,
    output logic        rd_en,
    output logic        busy,
    output logic [7:0]  fund_addr,
    output logic [15:0] fund_amp,
    output logic [15:0] h2_amp,
    output logic [15:0] h3_amp,
    output logic [15:0] h4_amp,
    output logic [15:0] h5_amp,
    output logic        done
);

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned HW = 11;

    typedef enum logic [2:0] {
        IDLE, SCAN, SCAN_FLUSH, HARM, HARM_FLUSH, DONE
    } state_t;

    state_t        state, state_nxt;
    logic          wr_done_d, armed, start_q;
    logic [1:0]    kidx, kidx_nxt;
    logic          rd_en_d, hslot_d;
    logic [1:0]    hidx_d;
    logic [AW-1:0] addr_d;
    logic [AW-1:0] run_idx, run_idx_nxt;
    logic [DW-1:0] run_amp, run_amp_nxt;
    logic [DW-1:0] h_amp [4];

    logic          rd_en_nxt, busy_nxt, done_nxt;
    logic [AW-1:0] rd_addr_nxt;
    logic          clr_c, ld_fund_c, harm_issue_c, run_upd_c;
    logic [AW-1:0] hsrc_c;
    logic [2:0]    mult_c;
    logic [HW-1:0] haddr_c;

    assign h2_amp = h_amp[0];
    assign h3_amp = h_amp[1];
    assign h4_amp = h_amp[2];
    assign h5_amp = h_amp[3];

    // Running peak: strict greater-than keeps the lowest index on ties
    always_comb begin
        run_upd_c   = rd_en_d && !hslot_d && (rd_data > run_amp);
        run_idx_nxt = run_upd_c ? addr_d  : run_idx;
        run_amp_nxt = run_upd_c ? rd_data : run_amp;
    end

    // Next-state and registered-output values
    always_comb begin
        state_nxt    = state;
        rd_en_nxt    = 1'b0;
        rd_addr_nxt  = rd_addr;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        kidx_nxt     = kidx;
        clr_c        = 1'b0;
        ld_fund_c    = 1'b0;
        harm_issue_c = 1'b0;
        hsrc_c       = fund_addr;

        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                if (start_q) begin
                    state_nxt   = SCAN;
                    rd_addr_nxt = AW'(DC_SKIP);
                    rd_en_nxt   = 1'b1;
                    busy_nxt    = 1'b1;
                    clr_c       = 1'b1;
                end
            end
            SCAN: begin
                if (rd_addr == AW'(DEPTH - 1)) begin
                    state_nxt = SCAN_FLUSH;
                end else begin
                    rd_addr_nxt = rd_addr + AW'(1);
                    rd_en_nxt   = 1'b1;
                end
            end
            SCAN_FLUSH: begin
                // last scan word lands this cycle, so use the updated peak
                state_nxt    = HARM;
                kidx_nxt     = 2'd0;
                ld_fund_c    = 1'b1;
                hsrc_c       = run_idx_nxt;
                harm_issue_c = 1'b1;
            end
            HARM: begin
                if (kidx == 2'd3) begin
                    state_nxt = HARM_FLUSH;
                end else begin
                    kidx_nxt     = kidx + 2'd1;
                    harm_issue_c = 1'b1;
                end
            end
            HARM_FLUSH: begin
                state_nxt = DONE;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase

        mult_c  = 3'(kidx_nxt) + 3'd2;
        haddr_c = HW'(hsrc_c) * HW'(mult_c);
        if (harm_issue_c && (haddr_c <= HW'(DEPTH - 1))) begin
            rd_en_nxt   = 1'b1;
            rd_addr_nxt = haddr_c[AW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_done_d <= 1'b0;
            armed     <= 1'b0;
            start_q   <= 1'b0;
            kidx      <= 2'd0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en_d   <= 1'b0;
            hslot_d   <= 1'b0;
            hidx_d    <= 2'd0;
            addr_d    <= '0;
            run_idx   <= '0;
            run_amp   <= '0;
            fund_addr <= '0;
            fund_amp  <= '0;
            for (int i = 0; i < 4; i++) h_amp[i] <= '0;
        end else begin
            state     <= state_nxt;
            // first sample after reset only primes the edge detector
            armed     <= 1'b1;
            wr_done_d <= wr_done;
            start_q   <= armed & wr_done & ~wr_done_d;
            kidx      <= kidx_nxt;
            rd_en     <= rd_en_nxt;
            rd_addr   <= rd_addr_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            rd_en_d   <= rd_en;
            hslot_d   <= (state == HARM);
            hidx_d    <= kidx;
            addr_d    <= rd_addr;

            if (clr_c) begin
                run_idx   <= AW'(DC_SKIP);
                run_amp   <= '0;
                fund_addr <= '0;
                fund_amp  <= '0;
                for (int i = 0; i < 4; i++) h_amp[i] <= '0;
            end else begin
                run_idx <= run_idx_nxt;
                run_amp <= run_amp_nxt;
                if (ld_fund_c) begin
                    fund_addr <= run_idx_nxt;
                    fund_amp  <= run_amp_nxt;
                end
                // out-of-range harmonics had no read issued and load zero
                if (hslot_d) h_amp[hidx_d] <= rd_en_d ? rd_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_ram_rd_ctrl_wave.sv
// Directed bench for ram_rd_ctrl_wave: vector table of spectra plus
// retrigger, start-while-busy and mid-run reset sequences.
module tb_ram_rd_ctrl_wave;

    localparam int unsigned DEPTH   = 254;
    localparam int unsigned DC_SKIP = 2;
    localparam int          LAT     = DEPTH - DC_SKIP + 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_done = 1'b0;
    logic [15:0] rd_data = '0;
    logic [7:0]  rd_addr, fund_addr;
    logic        rd_en, busy, done;
    logic [15:0] fund_amp, h2_amp, h3_amp, h4_amp, h5_amp;

    ram_rd_ctrl_wave #(.DEPTH(DEPTH), .DC_SKIP(DC_SKIP)) dut (
        .clk(clk), .rst(rst), .wr_done(wr_done), .rd_data(rd_data),
        .rd_addr(rd_addr), .rd_en(rd_en), .busy(busy),
        .fund_addr(fund_addr), .fund_amp(fund_amp),
        .h2_amp(h2_amp), .h3_amp(h3_amp), .h4_amp(h4_amp), .h5_amp(h5_amp),
        .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int en_cnt = 0, done_cnt = 0, busy_cnt = 0, bad_addr = 0;
    always @(negedge clk) begin
        if (rd_en) begin
            en_cnt++;
            if (rd_addr > 8'd253) bad_addr++;
        end
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int nb;
        int ba [5];
        int bv [5];
        int fa, famp, h2, h3, h4, h5, en;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mkv(input int nb,
                                 input int a0, input int a1, input int a2, input int a3, input int a4,
                                 input int v0, input int v1, input int v2, input int v3, input int v4,
                                 input int fa, input int famp,
                                 input int h2, input int h3, input int h4, input int h5,
                                 input int en);
        vec_t v;
        v.nb = nb;
        v.ba[0] = a0; v.ba[1] = a1; v.ba[2] = a2; v.ba[3] = a3; v.ba[4] = a4;
        v.bv[0] = v0; v.bv[1] = v1; v.bv[2] = v2; v.bv[3] = v3; v.bv[4] = v4;
        v.fa = fa; v.famp = famp;
        v.h2 = h2; v.h3 = h3; v.h4 = h4; v.h5 = h5;
        v.en = en;
        return v;
    endfunction

    task automatic load_mem(input int vi);
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int j = 0; j < vecs[vi].nb; j++) mem[vecs[vi].ba[j]] = 16'(vecs[vi].bv[j]);
    endtask

    task automatic chk_results(input string tag, input int vi);
        chk({tag, " fund_addr"}, int'(fund_addr), vecs[vi].fa);
        chk({tag, " fund_amp"},  int'(fund_amp),  vecs[vi].famp);
        chk({tag, " h2_amp"},    int'(h2_amp),    vecs[vi].h2);
        chk({tag, " h3_amp"},    int'(h3_amp),    vecs[vi].h3);
        chk({tag, " h4_amp"},    int'(h4_amp),    vecs[vi].h4);
        chk({tag, " h5_amp"},    int'(h5_amp),    vecs[vi].h5);
    endtask

    // Raise wr_done and watch a fixed window; returns cycles from start detect to done
    task automatic run(input string tag, input int toggle_at, output int lat);
        lat = -1;
        @(negedge clk) wr_done = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= LAT + 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) begin
                chk({tag, " T+1 rd_addr"}, int'(rd_addr), DC_SKIP);
                chk({tag, " T+1 rd_en"}, int'(rd_en), 1);
                chk({tag, " T+1 busy"}, int'(busy), 1);
                chk({tag, " T+1 fund_addr clr"}, int'(fund_addr), 0);
                chk({tag, " T+1 fund_amp clr"}, int'(fund_amp), 0);
                chk({tag, " T+1 h2 clr"}, int'(h2_amp), 0);
            end
            if (toggle_at > 0 && n == toggle_at - 2) wr_done = 1'b0;
            if (toggle_at > 0 && n == toggle_at) wr_done = 1'b1;
            if (done && lat < 0) begin
                lat = n;
                chk({tag, " busy at done"}, int'(busy), 0);
            end
        end
    endtask

    task automatic run_vec(input string tag, input int vi, input int toggle_at);
        int d0, e0, lat;
        load_mem(vi);
        @(negedge clk) wr_done = 1'b0;
        repeat (3) @(negedge clk);
        d0 = done_cnt;
        e0 = en_cnt;
        run(tag, toggle_at, lat);
        chk({tag, " latency"}, lat, LAT);
        chk({tag, " done pulses"}, done_cnt - d0, 1);
        chk({tag, " rd_en cycles"}, en_cnt - e0, vecs[vi].en);
        chk_results(tag, vi);
    endtask

    initial begin
        int d0, b0;
        vecs[0] = mkv(5, 40, 80, 120, 160, 200, 1000, 300, 200, 100, 50, 40, 1000, 300, 200, 100, 50, 256);
        vecs[1] = mkv(4, 0, 1, 30, 90, 0, 65535, 65535, 500, 500, 0, 30, 500, 0, 500, 0, 0, 256);
        vecs[2] = mkv(3, 70, 140, 210, 0, 0, 800, 40, 20, 0, 0, 70, 800, 40, 20, 0, 0, 254);
        vecs[3] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 256);
        vecs[4] = mkv(2, 253, 2, 0, 0, 0, 7, 5, 0, 0, 0, 253, 7, 0, 0, 0, 0, 252);
        vecs[5] = mkv(5, 2, 4, 6, 8, 100, 9, 1, 2, 3, 9, 2, 9, 1, 2, 3, 0, 256);
        vecs[6] = mkv(3, 126, 252, 253, 0, 0, 9, 3, 8, 0, 0, 126, 9, 3, 0, 0, 0, 253);
        for (int i = 0; i < 256; i++) mem[i] = '0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset rd_en", int'(rd_en), 0);
        chk("reset rd_addr", int'(rd_addr), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset fund_addr", int'(fund_addr), 0);
        chk("reset fund_amp", int'(fund_amp), 0);
        chk("reset harmonics", int'(h2_amp | h3_amp | h4_amp | h5_amp), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int vi = 0; vi < 7; vi++) run_vec($sformatf("vec%0d", vi), vi, 0);
        chk("rd_addr range", bad_addr, 0);

        // wr_done held high after the run: no second run
        d0 = done_cnt;
        b0 = busy_cnt;
        repeat (300) @(negedge clk);
        chk("hold-high done", done_cnt - d0, 0);
        chk("hold-high busy", busy_cnt - b0, 0);
        chk_results("hold-high", 6);

        // new edge while busy is ignored
        run_vec("busy-toggle", 0, 50);

        // reset mid-run with wr_done held high
        @(negedge clk) wr_done = 1'b0;
        repeat (3) @(negedge clk);
        wr_done = 1'b1;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst rd_en", int'(rd_en), 0);
        chk("midrst rd_addr", int'(rd_addr), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst results", int'(fund_addr) | int'(fund_amp | h2_amp | h3_amp | h4_amp | h5_amp), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        b0 = busy_cnt;
        repeat (300) @(negedge clk);
        chk("post-rst no done", done_cnt - d0, 0);
        chk("post-rst no busy", busy_cnt - b0, 0);
        run_vec("post-rst", 1, 0);
        chk("rd_addr range final", bad_addr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
